of_lookup_arbiter: RTL and testbench
====================================

Name: of_lookup_arbiter

Overview:
Shares one flow-table lookup engine between NREQ forwarder instances, one per physical port. Each forwarder fires a single-cycle lookup request with a 243-bit match key. The arbiter latches every request into a per-requester slot and serves the slots round-robin, one outstanding table lookup at a time. It returns the table's forwarding-port vector to the requester that owns it, as a one-cycle ack.

Parameters:
NREQ, 4, number of requesting forwarders (2..8)
NPORT, 4, width of forwarding-port vector
DATA_W, 243, match-key width
TIMEOUT, 64, cycles to wait for table ack (only with LOOKUP_TIMEOUT_EN)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  asynchronous, active-high reset
req_lookup  in  NREQ  per-requester one-cycle lookup request
req_data  in  NREQ*DATA_W  keys; requester i at [i*DATA_W +: DATA_W]; valid in req cycle only
req_ack  out  NREQ  one-cycle ack to the owning requester
req_fwd_port  out  NPORT  result vector, shared; valid while any req_ack bit is high
req_overrun  out  NREQ  one-cycle flag: request arrived while that slot was already pending
tbl_req  out  1  one-cycle lookup strobe to flow table
tbl_data  out  DATA_W  registered key, held stable from tbl_req until ack
tbl_ack  in  1  flow-table done
tbl_fwd_port  in  NPORT  table result, sampled with tbl_ack

Behaviour:
- Reset (async, sys_rst=1). All outputs 0. pending=0, slot keys=0, rr_ptr=0, grant=0, FSM=IDLE.
- Capture, every cycle, for each i with req_lookup[i]=1:
  - If pending[i]=0: slot[i]<=req_data[i]; pending[i]<=1.
  - If pending[i]=1 and slot i is not being acked this cycle: keep the old key, pulse req_overrun[i].
  - If slot i is being acked this same cycle: the new request wins. pending[i] stays 1, the new key is stored, no overrun.
- FSM state IDLE:
  - If pending≠0: grant<=first pending index at or after rr_ptr, cyclic.
  - Same edge: tbl_data<=that slot's key, tbl_req<=1 for exactly one cycle, go to WAIT.
- FSM state WAIT:
  - tbl_ack is sampled from the cycle tbl_req is high onward.
  - On tbl_ack: req_ack[grant]<=1 for one cycle, req_fwd_port<=tbl_fwd_port, pending[grant]<=0, rr_ptr<=(grant+1) mod NREQ, go to IDLE.
  - Otherwise stay in WAIT.
- Timing:
  - tbl_ack in IDLE is ignored.
  - tbl_data does not change in WAIT.
  - req_fwd_port holds its last value between acks.
- Latency:
  - req at cycle T: pending at T+1, tbl_req at T+2.
  - Table ack at cycle A: req_ack at A+1.
  - Minimum is 3 cycles, with tbl_ack in the same cycle as tbl_req.
  - After an ack, the next tbl_req comes ≥2 cycles after the previous tbl_ack.
- Fairness: with all slots continuously pending, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ lookups.
- Simultaneous requests in one cycle: all are captured; service order follows rr_ptr.
- Reset mid-lookup: everything clears, and the in-flight result is discarded. A later stray tbl_ack arrives in IDLE and is ignored.

Optional Feature:
LOOKUP_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT and restarts on entry.
  - If TIMEOUT cycles pass without tbl_ack, the arbiter acks the granted requester with req_fwd_port=0 (drop), clears its pending bit, advances rr_ptr and returns to IDLE.
  - Adds output tbl_timeout (1 bit): a one-cycle pulse with that ack, reset 0.
  - A tbl_ack arriving on the expiry cycle takes precedence: the real result is delivered and tbl_timeout stays 0.
- Undefined: no counter and no tbl_timeout port; WAIT waits indefinitely.

Test Plan:
- Single request: req_lookup=4'b0100 at T with key K; table acks at T+2 with 4'b1001. Expect tbl_req at T+2 with tbl_data=K, req_ack=4'b0100 at T+3, req_fwd_port=4'b1001.
- Simultaneous requests: req_lookup=4'b1111 in one cycle with distinct keys; table acks 1 cycle after each tbl_req. Expect tbl_data order slot0,1,2,3, req_ack order 0001,0010,0100,1000, and each req_fwd_port matching its key.
- Round-robin: slot2 served; then slots 0 and 3 pend together. Expect slot3 granted before slot0.
- Overrun and collision:
  - Second req on slot1 while its first lookup is in WAIT: expect req_overrun[1]=1 and the first key kept.
  - Req on slot1 in its ack cycle: no overrun, and the new key is issued next.
- Reset mid-WAIT: assert sys_rst for 1 cycle during WAIT, then tbl_ack. Expect no req_ack, all outputs 0, next request served normally.
- With LOOKUP_TIMEOUT_EN and TIMEOUT=64, no tbl_ack: expect req_ack with req_fwd_port=0 and tbl_timeout=1 exactly 64 cycles after entering WAIT.

Source files
------------

// File: rtl/of_lookup_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : of_lookup_arbiter_if
//  Description : Bundles the requester-side and flow-table-side signals of
//                the lookup arbiter into one interface.
//                  slave  modport : the arbiter itself
//                  master modport : forwarders plus flow table (environment)
//                Requester side : req_lookup, req_data, req_ack,
//                                 req_fwd_port, req_overrun
//                Table side     : tbl_req, tbl_data, tbl_ack, tbl_fwd_port,
//                                 tbl_timeout (only with LOOKUP_TIMEOUT_EN)
//  Config      : LOOKUP_TIMEOUT_EN adds the tbl_timeout signal
//  Revision    : 1.0  initial release
// ============================================================================
interface of_lookup_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int NPORT  = 4,
    parameter int DATA_W = 243
);
    logic [NREQ-1:0]        req_lookup;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ack;
    logic [NPORT-1:0]       req_fwd_port;
    logic [NREQ-1:0]        req_overrun;
    logic                   tbl_req;
    logic [DATA_W-1:0]      tbl_data;
    logic                   tbl_ack;
    logic [NPORT-1:0]       tbl_fwd_port;
`ifdef LOOKUP_TIMEOUT_EN
    logic                   tbl_timeout;
`endif

    modport slave (
        input  req_lookup, req_data, tbl_ack, tbl_fwd_port,
`ifdef LOOKUP_TIMEOUT_EN
        output tbl_timeout,
`endif
        output req_ack, req_fwd_port, req_overrun, tbl_req, tbl_data
    );

    modport master (
        output req_lookup, req_data, tbl_ack, tbl_fwd_port,
`ifdef LOOKUP_TIMEOUT_EN
        input  tbl_timeout,
`endif
        input  req_ack, req_fwd_port, req_overrun, tbl_req, tbl_data
    );
endinterface
`default_nettype wire

// File: rtl/of_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : of_lookup_arbiter
//  Description : Shares a single flow-table lookup engine between NREQ
//                forwarders. Each one-cycle request is latched into a
//                per-requester slot; pending slots are served round-robin
//                with one table lookup outstanding at a time, and the result
//                is returned to the owner as a one-cycle ack.
//  Ports       : sys_clk  - clock
//                sys_rst  - asynchronous active-high reset
//                bus      - of_lookup_arbiter_if.slave (requester + table side)
//  Config      : LOOKUP_TIMEOUT_EN - when defined, a lookup that sees no
//                tbl_ack for TIMEOUT cycles is dropped (ack with an all-zero
//                port vector) and tbl_timeout pulses with that ack.
//  Revision    : 1.0  initial release
// ============================================================================
module of_lookup_arbiter #(
    parameter int NREQ    = 4,
    parameter int NPORT   = 4,
    parameter int DATA_W  = 243
`ifdef LOOKUP_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  wire                  sys_clk,
    input  wire                  sys_rst,
    of_lookup_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_tbl_req;
    logic [DATA_W-1:0]  r_tbl_data;
    logic [NREQ-1:0]    r_req_ack;
    logic [NPORT-1:0]   r_fwd_port;

    logic [NREQ-1:0]    r_pending;
    logic [NREQ-1:0]    r_overrun;
    logic [DATA_W-1:0]  r_slot [NREQ];

    logic [IDX_W-1:0]   w_pick;
    logic               w_any;
    logic [NREQ-1:0]    w_grant_oh;
    logic [IDX_W-1:0]   w_next_ptr;
    logic               w_expire;
    logic               w_done;
    logic [NREQ-1:0]    w_clr;

    // ------------------------------------------------------------------
    // Round-robin pick: first pending slot at or after r_rr_ptr, wrapping.
    // ------------------------------------------------------------------
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % NREQ);
    endfunction

    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && r_pending[wrap_idx(int'(r_rr_ptr) + k)]) begin
                w_any  = 1'b1;
                w_pick = wrap_idx(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_grant_oh = NREQ'(1) << r_grant;
    assign w_next_ptr = (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + IDX_W'(1);

    // The lookup completes this cycle either with a real table ack or, when
    // enabled, by expiring. Either way the granted slot is released.
    assign w_done = (r_state == S_WAIT) && (bus.tbl_ack || w_expire);
    assign w_clr  = w_done ? w_grant_oh : '0;

`ifdef LOOKUP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // r_cnt is 0 in the tbl_req cycle, so it reads TIMEOUT-1 in the last
    // cycle of the window; the drop ack then lands TIMEOUT cycles after
    // WAIT was entered.
    assign w_expire        = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign bus.tbl_timeout = r_timeout;
`else
    assign w_expire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request capture. A request on a slot being released this very cycle
    // re-arms it with the new key rather than flagging an overrun.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pending <= '0;
            r_overrun <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                r_overrun[i] <= 1'b0;
                if (bus.req_lookup[i]) begin
                    if (!r_pending[i] || w_clr[i]) begin
                        r_slot[i]    <= bus.req_data[i*DATA_W +: DATA_W];
                        r_pending[i] <= 1'b1;
                    end else begin
                        r_overrun[i] <= 1'b1;
                    end
                end else if (w_clr[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup FSM. All outputs are registered; strobes default low.
    // The granted slot stays pending until its lookup completes, so its
    // key cannot change under tbl_data while in WAIT.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_tbl_req  <= 1'b0;
            r_tbl_data <= '0;
            r_req_ack  <= '0;
            r_fwd_port <= '0;
`ifdef LOOKUP_TIMEOUT_EN
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_tbl_req <= 1'b0;
            r_req_ack <= '0;
`ifdef LOOKUP_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // tbl_ack seen here is stale (e.g. after a reset) and ignored
                    if (w_any) begin
                        r_grant    <= w_pick;
                        r_tbl_data <= r_slot[w_pick];
                        r_tbl_req  <= 1'b1;
                        r_state    <= S_WAIT;
`ifdef LOOKUP_TIMEOUT_EN
                        r_cnt      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus.tbl_ack) begin
                        r_req_ack  <= w_grant_oh;
                        r_fwd_port <= bus.tbl_fwd_port;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= S_IDLE;
`ifdef LOOKUP_TIMEOUT_EN
                    end else if (w_expire) begin
                        r_req_ack  <= w_grant_oh;
                        r_fwd_port <= '0;
                        r_timeout  <= 1'b1;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt      <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack      = r_req_ack;
    assign bus.req_fwd_port = r_fwd_port;
    assign bus.req_overrun  = r_overrun;
    assign bus.tbl_req      = r_tbl_req;
    assign bus.tbl_data     = r_tbl_data;

endmodule
`default_nettype wire

// File: tb/tb_of_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_of_lookup_arbiter
//  Description : Self-checking bench for of_lookup_arbiter: a table of
//                single-lookup vectors, hand-written multi-cycle sequences
//                (simultaneous requests, round-robin, overrun, ack-cycle
//                collision, reset mid-lookup, timeout / long wait) and a
//                randomized phase checked against a slot/queue reference
//                model. Timeout checks need LOOKUP_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_of_lookup_arbiter;

    localparam int NREQ   = 4;
    localparam int NPORT  = 4;
    localparam int DATA_W = 243;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    of_lookup_arbiter_if #(.NREQ(NREQ), .NPORT(NPORT), .DATA_W(DATA_W)) bus ();

    of_lookup_arbiter #(.NREQ(NREQ), .NPORT(NPORT), .DATA_W(DATA_W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int               slot;
        logic [DATA_W-1:0] key;
        logic [NPORT-1:0] fwd;
        int               delay;
        logic [NREQ-1:0]  exp_ack;
    } vec_t;

    vec_t vecs [5];

    // reference model state for the randomized phase
    logic [NREQ-1:0]   m_pend;
    logic [DATA_W-1:0] m_key [NREQ];
    int                m_ptr, m_grant, m_wait, m_delay;
    bit                m_busy;
    logic [DATA_W-1:0] m_issued;
    logic [NPORT-1:0]  m_fwd;
    logic [NREQ-1:0]   e_ack, e_ovr;
    logic              e_treq;
    logic [NREQ-1:0]   r_mask, pend_pre;
    logic [DATA_W-1:0] r_nk [NREQ];
    logic              r_dack, mack;
    logic [NPORT-1:0]  r_dfwd;
    logic [DATA_W-1:0] k0, k1, k2, k3;
    logic [DATA_W-1:0] sk [NREQ];

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_key();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w[DATA_W-1:0];
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] pend, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return 0;
    endfunction

    // deassert all requests; keys become garbage outside the request cycle
    task automatic clear_req();
        bus.req_lookup = '0;
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DATA_W +: DATA_W] = rand_key();
    endtask

    task automatic add_req(input int slot, input logic [DATA_W-1:0] key);
        bus.req_lookup[slot] = 1'b1;
        bus.req_data[slot*DATA_W +: DATA_W] = key;
    endtask

    // Wait (bounded) for tbl_req, check its key, ack after 'delay' cycles,
    // optionally injecting requests in the ack cycle, then check the ack.
    task automatic serve_one(input logic [NREQ-1:0] exp_ack, input logic [DATA_W-1:0] key,
                             input logic [NPORT-1:0] fwd, input int delay, input int max_wait,
                             input logic [NREQ-1:0] inj_mask, input logic [DATA_W-1:0] inj_key);
        int n;
        n = 0;
        while (!bus.tbl_req && n < max_wait) begin
            step();
            n++;
        end
        chk("tbl_req_issued", 256'(bus.tbl_req), 256'(1));
        chk("tbl_data_key", 256'(bus.tbl_data), 256'(key));
        for (int d = 0; d < delay; d++) begin
            step();
            chk("tbl_req_one_cycle", 256'(bus.tbl_req), 256'(0));
            chk("tbl_data_hold", 256'(bus.tbl_data), 256'(key));
            chk("no_early_ack", 256'(bus.req_ack), 256'(0));
        end
        bus.tbl_ack = 1'b1;
        bus.tbl_fwd_port = fwd;
        for (int i = 0; i < NREQ; i++) if (inj_mask[i]) add_req(i, inj_key);
        step();
        bus.tbl_ack = 1'b0;
        bus.tbl_fwd_port = NPORT'($urandom);
        clear_req();
        chk("req_ack", 256'(bus.req_ack), 256'(exp_ack));
        chk("req_fwd_port", 256'(bus.req_fwd_port), 256'(fwd));
        chk("no_overrun", 256'(bus.req_overrun), 256'(0));
    endtask

    task automatic reset_pulse();
        clear_req();
        bus.tbl_ack = 1'b0;
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{slot: 2, key: rand_key(), fwd: 4'b1001, delay: 0, exp_ack: 4'b0100};
        vecs[1] = '{slot: 0, key: rand_key(), fwd: 4'b0110, delay: 1, exp_ack: 4'b0001};
        vecs[2] = '{slot: 1, key: rand_key(), fwd: 4'b1111, delay: 3, exp_ack: 4'b0010};
        vecs[3] = '{slot: 1, key: rand_key(), fwd: 4'b0001, delay: 0, exp_ack: 4'b0010};
        vecs[4] = '{slot: 3, key: rand_key(), fwd: 4'b1010, delay: 2, exp_ack: 4'b1000};

        bus.req_lookup = '0;
        bus.req_data = '0;
        bus.tbl_ack = 1'b0;
        bus.tbl_fwd_port = '0;
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_req_ack", 256'(bus.req_ack), 256'(0));
        chk("rst_fwd", 256'(bus.req_fwd_port), 256'(0));
        chk("rst_overrun", 256'(bus.req_overrun), 256'(0));
        chk("rst_tbl_req", 256'(bus.tbl_req), 256'(0));
        chk("rst_tbl_data", 256'(bus.tbl_data), 256'(0));
`ifdef LOOKUP_TIMEOUT_EN
        chk("rst_timeout", 256'(bus.tbl_timeout), 256'(0));
`endif
        sys_rst = 1'b0;

        // ---- table-driven single lookups (exact 2-cycle issue latency) ----
        for (int v = 0; v < 5; v++) begin
            add_req(vecs[v].slot, vecs[v].key);
            step();
            clear_req();
            chk("vec_no_early_tbl_req", 256'(bus.tbl_req), 256'(0));
            step();
            serve_one(vecs[v].exp_ack, vecs[v].key, vecs[v].fwd, vecs[v].delay, 0, '0, '0);
        end

        // ---- simultaneous requests: served 0,1,2,3 (rr_ptr wrapped to 0) ----
        for (int i = 0; i < NREQ; i++) begin
            sk[i] = rand_key();
            add_req(i, sk[i]);
        end
        step();
        clear_req();
        step();
        for (int i = 0; i < NREQ; i++)
            serve_one(NREQ'(1) << i, sk[i], NPORT'(i * 3 + 5), 1, 3, '0, '0);

        // ---- round robin: after slot2, slot3 beats slot0 ----
        k2 = rand_key();
        add_req(2, k2);
        step(); clear_req(); step();
        serve_one(4'b0100, k2, 4'b0011, 0, 0, '0, '0);
        k0 = rand_key();
        k3 = rand_key();
        add_req(0, k0);
        add_req(3, k3);
        step(); clear_req(); step();
        serve_one(4'b1000, k3, 4'b1100, 0, 0, '0, '0);
        serve_one(4'b0001, k0, 4'b0101, 0, 3, '0, '0);

        // ---- overrun: second request on slot1 while in WAIT ----
        k1 = rand_key();
        add_req(1, k1);
        step(); clear_req(); step();
        chk("ovr_tbl_req", 256'(bus.tbl_req), 256'(1));
        chk("ovr_tbl_data", 256'(bus.tbl_data), 256'(k1));
        add_req(1, rand_key());
        step();
        clear_req();
        chk("ovr_flag", 256'(bus.req_overrun), 256'(4'b0010));
        chk("ovr_key_kept", 256'(bus.tbl_data), 256'(k1));
        bus.tbl_ack = 1'b1;
        bus.tbl_fwd_port = 4'b0111;
        step();
        bus.tbl_ack = 1'b0;
        chk("ovr_ack", 256'(bus.req_ack), 256'(4'b0010));
        chk("ovr_fwd", 256'(bus.req_fwd_port), 256'(4'b0111));
        chk("ovr_flag_clear", 256'(bus.req_overrun), 256'(0));
        step();
        step();
        chk("ovr_no_reissue", 256'(bus.tbl_req), 256'(0));

        // ---- collision: new slot1 request in its own ack cycle ----
        k1 = rand_key();
        k2 = rand_key();
        add_req(1, k1);
        step(); clear_req(); step();
        serve_one(4'b0010, k1, 4'b1110, 1, 0, 4'b0010, k2);
        serve_one(4'b0010, k2, 4'b1011, 0, 1, '0, '0);

        // ---- reset mid-WAIT, then a stray ack ----
        k0 = rand_key();
        add_req(0, k0);
        step(); clear_req(); step(); step();
        sys_rst = 1'b1;
        #1;
        chk("midrst_req_ack", 256'(bus.req_ack), 256'(0));
        chk("midrst_fwd", 256'(bus.req_fwd_port), 256'(0));
        chk("midrst_tbl_req", 256'(bus.tbl_req), 256'(0));
        chk("midrst_tbl_data", 256'(bus.tbl_data), 256'(0));
        step();
        sys_rst = 1'b0;
        bus.tbl_ack = 1'b1;
        bus.tbl_fwd_port = 4'b1111;
        step();
        bus.tbl_ack = 1'b0;
        chk("stray_ack_ignored", 256'(bus.req_ack), 256'(0));
        chk("stray_fwd_ignored", 256'(bus.req_fwd_port), 256'(0));
        step();
        chk("midrst_no_reissue", 256'(bus.tbl_req), 256'(0));
        k2 = rand_key();
        add_req(2, k2);
        step(); clear_req(); step();
        serve_one(4'b0100, k2, 4'b0110, 0, 0, '0, '0);

        // ---- randomized traffic against the reference model ----
        reset_pulse();
        m_pend = '0;
        for (int i = 0; i < NREQ; i++) m_key[i] = '0;
        m_ptr = 0; m_grant = 0; m_wait = 0; m_delay = 0; m_busy = 0;
        m_issued = '0; m_fwd = '0; e_ack = '0; e_ovr = '0; e_treq = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r_mask = NREQ'($urandom) & NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                r_nk[i] = rand_key();
                bus.req_data[i*DATA_W +: DATA_W] = r_nk[i];
            end
            bus.req_lookup = r_mask;
            r_dack = m_busy ? (m_wait >= m_delay) : ($urandom_range(0, 7) == 0);
            r_dfwd = NPORT'($urandom);
            bus.tbl_ack = r_dack;
            bus.tbl_fwd_port = r_dfwd;

            pend_pre = m_pend;
            mack = m_busy && r_dack;
            e_ack = '0; e_ovr = '0; e_treq = 1'b0;
            if (mack) begin
                e_ack[m_grant] = 1'b1;
                m_fwd = r_dfwd;
                m_pend[m_grant] = 1'b0;
                m_ptr = (m_grant + 1) % NREQ;
                m_busy = 0;
            end else if (m_busy) begin
                m_wait++;
            end else if (pend_pre != '0) begin
                m_grant = model_pick(pend_pre, m_ptr);
                m_issued = m_key[m_grant];
                m_busy = 1;
                m_wait = 0;
                m_delay = $urandom_range(0, 3);
                e_treq = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (r_mask[i]) begin
                    if (!pend_pre[i] || (mack && i == m_grant)) begin
                        m_key[i] = r_nk[i];
                        m_pend[i] = 1'b1;
                    end else begin
                        e_ovr[i] = 1'b1;
                    end
                end
            end

            step();
            chk("rnd_req_ack", 256'(bus.req_ack), 256'(e_ack));
            chk("rnd_fwd", 256'(bus.req_fwd_port), 256'(m_fwd));
            chk("rnd_overrun", 256'(bus.req_overrun), 256'(e_ovr));
            chk("rnd_tbl_req", 256'(bus.tbl_req), 256'(e_treq));
            if (m_busy) chk("rnd_tbl_data", 256'(bus.tbl_data), 256'(m_issued));
        end

        // ---- no-ack behaviour ----
        reset_pulse();
        k1 = rand_key();
        add_req(1, k1);
        step(); clear_req(); step();
        serve_one(4'b0010, k1, 4'b1111, 0, 0, '0, '0);
        k3 = rand_key();
        add_req(3, k3);
        step(); clear_req(); step();
`ifdef LOOKUP_TIMEOUT_EN
        chk("to_tbl_req", 256'(bus.tbl_req), 256'(1));
        for (int c = 1; c < 64; c++) begin
            step();
            chk("to_no_early_ack", 256'(bus.req_ack), 256'(0));
            chk("to_no_early_flag", 256'(bus.tbl_timeout), 256'(0));
        end
        step();
        chk("to_ack", 256'(bus.req_ack), 256'(4'b1000));
        chk("to_fwd_dropped", 256'(bus.req_fwd_port), 256'(0));
        chk("to_flag", 256'(bus.tbl_timeout), 256'(1));
        step();
        chk("to_flag_pulse", 256'(bus.tbl_timeout), 256'(0));
        chk("to_ack_pulse", 256'(bus.req_ack), 256'(0));
        // a real ack on the expiry cycle wins over the timeout
        k0 = rand_key();
        add_req(0, k0);
        step(); clear_req(); step();
        chk("to2_tbl_req", 256'(bus.tbl_req), 256'(1));
        repeat (63) step();
        bus.tbl_ack = 1'b1;
        bus.tbl_fwd_port = 4'b0110;
        step();
        bus.tbl_ack = 1'b0;
        chk("to2_ack", 256'(bus.req_ack), 256'(4'b0001));
        chk("to2_fwd_real", 256'(bus.req_fwd_port), 256'(4'b0110));
        chk("to2_no_flag", 256'(bus.tbl_timeout), 256'(0));
`else
        // without the timeout, WAIT holds indefinitely until the table answers
        serve_one(4'b1000, k3, 4'b0101, 100, 0, '0, '0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
